// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the KCPU bus-cycle generator: FSM encoding and
// counter-width helpers used to size ports and internal counters.
package jtkcpu_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } bus_state_t;

  function automatic int phase_w(input int nph);
    return (nph > 1) ? $clog2(nph) : 1;
  endfunction

  // A disabled timeout (TOUT=0) still needs a one-bit counter to stay legal.
  function automatic int tout_w(input int tout);
    return (tout > 0) ? $clog2(tout + 1) : 1;
  endfunction

endpackage

// File: rtl/jtkcpu_busgen_tout.sv
// Dtack timeout tracker: counts stalled bus ticks and raises a sticky bus
// error when the slave has held dtack low for TOUT ticks.
module jtkcpu_busgen_tout
  import jtkcpu_pkg::*;
#(
  parameter int TOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic clr_cnt,
  input  logic err_clr,
  output logic bus_err
);

  localparam int CW = tout_w(TOUT);

  logic [CW-1:0] tcnt;

  // A timeout set is written after the clear so it wins when both coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt    <= '0;
      bus_err <= 1'b0;
    end else begin
      if (err_clr) bus_err <= 1'b0;
      if (stall) begin
        if (TOUT != 0 && tcnt == CW'(TOUT - 1)) begin
          bus_err <= 1'b1;
          tcnt    <= '0;
        end else begin
          tcnt <= (TOUT == 0) ? '0 : tcnt + 1'b1;
        end
      end else if (clr_cnt) begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/jtkcpu_busgen.sv
// Bus-cycle / clock-enable generator: turns cen2 into bus and CPU enables,
// inserting address-change wait states and dtack stretches.
module jtkcpu_busgen
  import jtkcpu_pkg::*;
#(
  parameter int AW    = 24,
  parameter int NPH   = 2,
  parameter int WAITW = 2,
  parameter int TOUT  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen2,
  input  logic [AW-1:0]           addr,
  input  logic                    dtack,
  input  logic [WAITW-1:0]        wait_cnt,
  input  logic                    err_clr,
  output logic                    cen_bus,
  output logic                    cen_cpu,
  output logic [phase_w(NPH)-1:0] phase,
  output logic                    busy,
  output logic                    bus_err
);

  localparam int PW = phase_w(NPH);

  bus_state_t     state, state_nxt;
  logic [AW-1:0]  addr_l;
  logic [WAITW-1:0] wcnt;
  logic           in_run, addr_wait, stall, accept, last_ph;

  assign in_run    = (state == RUN);
  assign addr_wait = (addr != addr_l) && (wait_cnt != '0);
  assign stall     = cen2 && in_run && !addr_wait && !dtack && !bus_err;
  assign accept    = cen2 && in_run && !addr_wait && (dtack || bus_err);
  assign last_ph   = (phase == PW'(NPH - 1));
  assign busy      = !in_run || (cen2 && !accept);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:  if (cen2 && addr_wait && wait_cnt > WAITW'(1)) state_nxt = WAIT;
      WAIT: if (cen2 && wcnt == WAITW'(1)) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // addr_l also follows addr during WAIT so a move mid-wait does not retrigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      addr_l  <= '0;
      wcnt    <= '0;
      phase   <= '0;
      cen_bus <= 1'b0;
      cen_cpu <= 1'b0;
    end else begin
      state   <= state_nxt;
      cen_bus <= 1'b0;
      cen_cpu <= 1'b0;
      if (cen2) begin
        if (!in_run) begin
          addr_l <= addr;
          wcnt   <= wcnt - 1'b1;
        end else if (addr_wait) begin
          addr_l <= addr;
          wcnt   <= wait_cnt - 1'b1;
        end else if (accept) begin
          addr_l  <= addr;
          cen_bus <= 1'b1;
          cen_cpu <= last_ph;
          phase   <= last_ph ? '0 : phase + 1'b1;
        end
      end
    end
  end

  jtkcpu_busgen_tout #(.TOUT(TOUT)) u_tout (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .clr_cnt (accept),
    .err_clr (err_clr),
    .bus_err (bus_err)
  );

endmodule

// File: tb/tb_jtkcpu_busgen.sv
// Directed bench for jtkcpu_busgen: three instances sharing stimulus
// (NPH=2/TOUT=255, NPH=2/TOUT=4, NPH=1/TOUT=255).
module tb_jtkcpu_busgen;

  logic        clk = 1'b0;
  logic        rst, cen2, dtack, err_clr;
  logic [23:0] addr;
  logic [1:0]  wait_cnt;

  logic       bus_a, cpu_a, busy_a, err_a;
  logic [0:0] ph_a;
  logic       bus_b, cpu_b, busy_b, err_b;
  logic [0:0] ph_b;
  logic       bus_c, cpu_c, busy_c, err_c;
  logic [0:0] ph_c;

  logic busy_a_s, busy_b_s;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  jtkcpu_busgen #(.AW(24), .NPH(2), .WAITW(2), .TOUT(255)) u_a (
    .clk(clk), .rst(rst), .cen2(cen2), .addr(addr), .dtack(dtack),
    .wait_cnt(wait_cnt), .err_clr(err_clr), .cen_bus(bus_a), .cen_cpu(cpu_a),
    .phase(ph_a), .busy(busy_a), .bus_err(err_a));

  jtkcpu_busgen #(.AW(24), .NPH(2), .WAITW(2), .TOUT(4)) u_b (
    .clk(clk), .rst(rst), .cen2(cen2), .addr(addr), .dtack(dtack),
    .wait_cnt(wait_cnt), .err_clr(err_clr), .cen_bus(bus_b), .cen_cpu(cpu_b),
    .phase(ph_b), .busy(busy_b), .bus_err(err_b));

  jtkcpu_busgen #(.AW(24), .NPH(1), .WAITW(2), .TOUT(255)) u_c (
    .clk(clk), .rst(rst), .cen2(cen2), .addr(addr), .dtack(dtack),
    .wait_cnt(wait_cnt), .err_clr(err_clr), .cen_bus(bus_c), .cen_cpu(cpu_c),
    .phase(ph_c), .busy(busy_c), .bus_err(err_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cen2 = 1'b0;
    repeat (n) step();
  endtask

  // One-clk cen2 pulse; busy is sampled before the accepting edge.
  task automatic tick();
    cen2 = 1'b1;
    #1;
    busy_a_s = busy_a;
    busy_b_s = busy_b;
    step();
    cen2 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cen2 = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cen2 = 1'b0; dtack = 1'b1; err_clr = 1'b0;
    addr = 24'h000100; wait_cnt = 2'd0;
    do_reset();

    // reset state
    chk("rst_bus", bus_a, 0);
    chk("rst_cpu", cpu_a, 0);
    chk("rst_phase", ph_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_busy", busy_a, 0);

    // 1: free-running ticks every 4 clk
    for (int k = 0; k < 4; k++) begin
      idle(3);
      chk("t1_idle_bus", bus_a, 0);
      tick();
      chk("t1_bus", bus_a, 1);
      chk("t1_cpu", cpu_a, (k % 2 == 1) ? 1 : 0);
      chk("t1_phase", ph_a, (k % 2 == 0) ? 1 : 0);
      chk("t1_nph1_cpu", cpu_c, 1);
      chk("t1_nph1_phase", ph_c, 0);
    end
    step();
    chk("t1_pulse_width", bus_a, 0);

    // 2: address change with three wait ticks, addr moves again mid-wait
    addr = 24'h000200; wait_cnt = 2'd3;
    tick();
    chk("t2_w1_busy", busy_a_s, 1);
    chk("t2_w1_bus", bus_a, 0);
    idle(2);
    chk("t2_wait_busy_idle", busy_a, 1);
    addr = 24'h000300;
    tick();
    chk("t2_w2_busy", busy_a_s, 1);
    chk("t2_w2_bus", bus_a, 0);
    tick();
    chk("t2_w3_busy", busy_a_s, 1);
    chk("t2_w3_bus", bus_a, 0);
    tick();
    chk("t2_acc_busy", busy_a_s, 0);
    chk("t2_acc_bus", bus_a, 1);
    chk("t2_acc_cpu", cpu_a, 0);
    tick();
    chk("t2_noretrig_bus", bus_a, 1);
    chk("t2_noretrig_cpu", cpu_a, 1);
    chk("t2_phase", ph_a, 0);
    wait_cnt = 2'd0;

    // 3: dtack low for 5 ticks, long timeout
    dtack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_stall_busy", busy_a_s, 1);
      chk("t3_stall_bus", bus_a, 0);
      chk("t3_phase_frozen", ph_a, 0);
      chk("t3_err", err_a, 0);
    end
    dtack = 1'b1;
    tick();
    chk("t3_resume_bus", bus_a, 1);
    chk("t3_resume_phase", ph_a, 1);

    // 4: TOUT=4 with dtack stuck low
    do_reset();
    tick();
    chk("t4_first_bus", bus_b, 1);
    dtack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t4_pre_err", err_b, 0);
      tick();
      chk("t4_stall_bus", bus_b, 0);
      chk("t4_stall_busy", busy_b_s, 1);
    end
    chk("t4_err_set", err_b, 1);
    tick();
    chk("t4_bypass_busy", busy_b_s, 0);
    chk("t4_bypass_bus", bus_b, 1);
    tick();
    chk("t4_bypass2_bus", bus_b, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_err_clr", err_b, 0);
    tick();
    chk("t4_stall_again_busy", busy_b_s, 1);
    chk("t4_stall_again_bus", bus_b, 0);
    dtack = 1'b1;

    // 5: reset while waiting (u_a phase is 1 here)
    chk("t5_pre_phase", ph_a, 1);
    addr = 24'h000500; wait_cnt = 2'd3;
    tick();
    tick();
    chk("t5_in_wait_busy", busy_a, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_bus", bus_a, 0);
    chk("t5_rst_phase", ph_a, 0);
    wait_cnt = 2'd1;
    tick();
    chk("t5_w1_busy", busy_a_s, 1);
    chk("t5_w1_bus", bus_a, 0);
    tick();
    chk("t5_acc_busy", busy_a_s, 0);
    chk("t5_acc_bus", bus_a, 1);
    wait_cnt = 2'd0;

    // 6: NPH=1 with cen2 held high
    do_reset();
    chk("t6_rst_bus", bus_c, 0);
    cen2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_bus", bus_c, 1);
      chk("t6_cpu", cpu_c, 1);
      chk("t6_phase", ph_c, 0);
    end
    cen2 = 1'b0;
    step();
    chk("t6_stop_bus", bus_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
